uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Byte-serial UART transmitter for the echo datapath. Accepts a level-sensitive send request plus an 8-bit byte from the send-request sequencer. Serialises the byte as an 8N1 frame (optionally 8E1) on `txOUT`. Reports activity on the active-low `nBusyOUT` line, which the sequencer uses to release and re-arm its request.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2; sets the baud counter width to ceil(log2(CLKS_PER_BIT)).
- `clkIN`  input  1  system clock; all state updates on its rising edge.
- `nResetIN`  input  1  reset, asynchronous, active-low.
- `sendIN`  input  1  transmit request, level-sensitive, sampled only in IDLE.
- `dataIN`  input  8  byte to send; captured on the accepting edge only.
- `txOUT`  output  1  serial line; idle/mark level = 1.
- `nBusyOUT`  output  1  0 while a frame is in progress, 1 when idle.
- `doneOUT`  output  1  one-cycle pulse coinciding with the return to IDLE.

## Operation
- States: IDLE, START, DATA, PARITY (only with the parity macro), STOP.
- IDLE:
  - Outputs are `txOUT`=1 and `nBusyOUT`=1.
  - If `sendIN`=1, load `dataIN` into the shift register, clear the baud counter and bit index, and go to START.
- START: `txOUT`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `txOUT` = shift register bit 0, so bits go out LSB first.
  - Each bit is held CLKS_PER_BIT cycles; the register then shifts right and the bit index increments.
  - After bit index 7 completes, go to PARITY or STOP.
- PARITY: `txOUT` = XOR of the captured byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `txOUT`=1 for CLKS_PER_BIT cycles, then go to IDLE with a `doneOUT` pulse.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - No drift: the bit boundary is exactly the cycle the counter equals CLKS_PER_BIT-1.
- Changes on `sendIN` and `dataIN` outside IDLE are ignored. No queuing: a request dropped before the frame ends is simply lost.
- `sendIN` still high on returning to IDLE starts another frame. The sequencer's deassertion after `nBusyOUT` falls prevents a repeat.

## Timing
- Reset (`nResetIN`=0, asynchronous, takes effect without a clock):
  - State IDLE; `txOUT`=1, `nBusyOUT`=1, `doneOUT`=0.
  - Shift register, counter and bit index cleared.
- Reset mid-frame aborts immediately: the line returns high and no partial stop bit is sent.
- Accept latency: `sendIN`=1 sampled in IDLE at edge E. From E onward, `txOUT`=0 (start bit) and `nBusyOUT`=0; both outputs are registered.
- Frame length from E:
  - 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
  - At the final edge, `nBusyOUT`=1 and `doneOUT`=1 for exactly one cycle.
- `nBusyOUT` stays high for ≥1 cycle between frames. Back-to-back frames are therefore separated by one idle clock at minimum, with the line kept at 1.
- Outputs are glitch-free: all three are driven from flops.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in and the frame is 8E1 (11 bits).
  - Parity bit = ^data, so the count of ones over data+parity is even.
- Not defined:
  - PARITY state and parity logic are absent and the frame is 8N1 (10 bits).
  - DATA goes directly to STOP.

## Test plan
- Reset: hold `nResetIN`=0 with random inputs, then release → `txOUT`=1, `nBusyOUT`=1, `doneOUT`=0. No frame starts until `sendIN`=1.
- Single byte, CLKS_PER_BIT=4, `dataIN`=0x55, `sendIN` pulsed for 1 cycle:
  - `txOUT` reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `nBusyOUT`=0 for exactly 40 cycles; `doneOUT` pulses once at cycle 40.
- Parity build with the macro defined, `dataIN`=0x07 → parity bit=1, 44-cycle frame. With `dataIN`=0x03 → parity bit=0.
- Data stability: change `dataIN` 0xA3→0xFF one cycle after acceptance → line carries 0xA3 (LSB first: 1,1,0,0,0,1,0,1).
- Held request: `sendIN` held at 1 for three frames → three consecutive frames, each separated by exactly one cycle with `nBusyOUT`=1 and `txOUT`=1.
- Reset mid-frame: assert `nResetIN` during data bit 3 → `txOUT`=1 and `nBusyOUT`=1 immediately. After release, a new request yields a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//
// Byte-serial UART transmitter for the echo datapath. A level-sensitive send
// request accepted in IDLE captures one byte, which is serialised LSB first as
// an 8N1 frame (start, 8 data, stop). With the UART_TX_PARITY_EN macro defined
// an even-parity bit is inserted before the stop bit, giving an 8E1 frame.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports:
//   clkIN     in   1  system clock, rising edge
//   nResetIN  in   1  asynchronous active-low reset
//   sendIN    in   1  transmit request, sampled only while idle
//   dataIN    in   8  byte to send, captured on the accepting edge
//   txOUT     out  1  serial line, idle level 1
//   nBusyOUT  out  1  0 while a frame is in progress
//   doneOUT   out  1  one-cycle pulse on the return to idle
//
// Build option:
//   UART_TX_PARITY_EN  compiles in the PARITY state (8E1 framing)
// -----------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clkIN,
    input  logic       nResetIN,
    input  logic       sendIN,
    input  logic [7:0] dataIN,
    output logic       txOUT,
    output logic       nBusyOUT,
    output logic       doneOUT
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } txState_t;
`endif

    txState_t         stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [2:0]       bitIdxReg, bitIdxNext;
    logic [7:0]       shiftReg, shiftNext;
    logic             txReg, txNext;
    logic             nBusyReg, nBusyNext;
    logic             doneReg, doneNext;
    logic             bitEnd;

`ifdef UART_TX_PARITY_EN
    // The shift register is consumed while sending, so parity is taken from
    // the byte at capture time and held for the PARITY bit.
    logic parityReg, parityNext;
`endif

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            stateReg  <= IDLE;
            cntReg    <= '0;
            bitIdxReg <= '0;
            shiftReg  <= '0;
            txReg     <= 1'b1;
            nBusyReg  <= 1'b1;
            doneReg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityReg <= 1'b0;
`endif
        end else begin
            stateReg  <= stateNext;
            cntReg    <= cntNext;
            bitIdxReg <= bitIdxNext;
            shiftReg  <= shiftNext;
            txReg     <= txNext;
            nBusyReg  <= nBusyNext;
            doneReg   <= doneNext;
`ifdef UART_TX_PARITY_EN
            parityReg <= parityNext;
`endif
        end
    end

    // Bit boundary: the cycle the baud counter sits at its last value.
    assign bitEnd = (cntReg == CNT_LAST);

    // ---------------------------------------------------------------------
    // Next-state and registered-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        stateNext  = stateReg;
        cntNext    = cntReg;
        bitIdxNext = bitIdxReg;
        shiftNext  = shiftReg;
        txNext     = 1'b1;
        nBusyNext  = 1'b1;
        doneNext   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parityNext = parityReg;
`endif

        // Baud counter runs in every non-idle state and wraps at each boundary.
        if (stateReg != IDLE) begin
            cntNext = bitEnd ? '0 : cntReg + CNT_W'(1);
        end

        case (stateReg)
            IDLE: begin
                if (sendIN) begin
                    shiftNext  = dataIN;
                    cntNext    = '0;
                    bitIdxNext = '0;
`ifdef UART_TX_PARITY_EN
                    parityNext = ^dataIN;
`endif
                    stateNext  = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftNext  = {1'b0, shiftReg[7:1]};
                    bitIdxNext = bitIdxReg + 3'd1;
                    if (bitIdxReg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that they change on the
        // same edge as the state itself while still coming straight from flops.
        case (stateNext)
            START: begin
                txNext    = 1'b0;
                nBusyNext = 1'b0;
            end
            DATA: begin
                txNext    = shiftNext[0];
                nBusyNext = 1'b0;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txNext    = parityNext;
                nBusyNext = 1'b0;
            end
`endif
            STOP: begin
                txNext    = 1'b1;
                nBusyNext = 1'b0;
            end
            default: begin
                txNext    = 1'b1;
                nBusyNext = 1'b1;
            end
        endcase
    end

    assign txOUT    = txReg;
    assign nBusyOUT = nBusyReg;
    assign doneOUT  = doneReg;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clkIN = 1'b0;
    logic       nResetIN;
    logic       sendIN;
    logic [7:0] dataIN;
    logic       txOUT;
    logic       nBusyOUT;
    logic       doneOUT;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
        .clkIN    (clkIN),
        .nResetIN (nResetIN),
        .sendIN   (sendIN),
        .dataIN   (dataIN),
        .txOUT    (txOUT),
        .nBusyOUT (nBusyOUT),
        .doneOUT  (doneOUT)
    );

    always #5 clkIN = ~clkIN;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic stepClk();
        @(posedge clkIN);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels, index 0 = start bit.
    function automatic logic [10:0] frameBits(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // Called just after the accepting edge E. Checks every cycle of the frame
    // and the done cycle, leaving time just after edge E + FRAME_CYC.
    task automatic checkFrame(input logic [7:0] d, input string name);
        logic [10:0] f;
        f = frameBits(d);
        for (int c = 0; c < FRAME_CYC; c++) begin
            chk($sformatf("%s tx c%0d", name, c), {7'd0, txOUT}, {7'd0, f[c / CPB]});
            chk($sformatf("%s nBusy c%0d", name, c), {7'd0, nBusyOUT}, 8'd0);
            chk($sformatf("%s done c%0d", name, c), {7'd0, doneOUT}, 8'd0);
            stepClk();
        end
        chk({name, " done pulse"}, {7'd0, doneOUT}, 8'd1);
        chk({name, " nBusy end"}, {7'd0, nBusyOUT}, 8'd1);
        chk({name, " tx end"}, {7'd0, txOUT}, 8'd1);
        $display("frame %s data=%02h checked (%0d cycles)", name, d, FRAME_CYC);
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        nResetIN = 1'b0;
        sendIN   = 1'b0;
        dataIN   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sendIN = 1'($urandom_range(0, 1));
            dataIN = 8'($urandom_range(0, 255));
            stepClk();
            chk("reset tx", {7'd0, txOUT}, 8'd1);
            chk("reset nBusy", {7'd0, nBusyOUT}, 8'd1);
            chk("reset done", {7'd0, doneOUT}, 8'd0);
        end
        sendIN   = 1'b0;
        dataIN   = 8'h00;
        nResetIN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepClk();
            chk("idle tx", {7'd0, txOUT}, 8'd1);
            chk("idle nBusy", {7'd0, nBusyOUT}, 8'd1);
            chk("idle done", {7'd0, doneOUT}, 8'd0);
        end
        $display("reset/idle checked");

        // ---------------- single byte 0x55, one-cycle request ----------------
        dataIN = 8'h55;
        sendIN = 1'b1;
        stepClk();
        sendIN = 1'b0;
        checkFrame(8'h55, "b55");
        stepClk();
        chk("b55 after done", {7'd0, doneOUT}, 8'd0);
        chk("b55 no restart", {7'd0, nBusyOUT}, 8'd1);

        // ---------------- parity-relevant bytes ----------------
        dataIN = 8'h07;
        sendIN = 1'b1;
        stepClk();
        sendIN = 1'b0;
        checkFrame(8'h07, "b07");
        stepClk();
        dataIN = 8'h03;
        sendIN = 1'b1;
        stepClk();
        sendIN = 1'b0;
        checkFrame(8'h03, "b03");
        stepClk();

        // ---------------- data stability ----------------
        dataIN = 8'hA3;
        sendIN = 1'b1;
        stepClk();
        sendIN = 1'b0;
        dataIN = 8'hFF;
        checkFrame(8'hA3, "bA3");
        stepClk();

        // ---------------- held request: three frames ----------------
        dataIN = 8'h3C;
        sendIN = 1'b1;
        stepClk();
        checkFrame(8'h3C, "held1");
        stepClk();
        checkFrame(8'h3C, "held2");
        stepClk();
        checkFrame(8'h3C, "held3");
        sendIN = 1'b0;
        stepClk();
        chk("held idle nBusy", {7'd0, nBusyOUT}, 8'd1);
        chk("held idle done", {7'd0, doneOUT}, 8'd0);
        chk("held idle tx", {7'd0, txOUT}, 8'd1);

        // ---------------- reset mid-frame during data bit 3 ----------------
        dataIN = 8'hF0;
        sendIN = 1'b1;
        stepClk();
        sendIN = 1'b0;
        for (int i = 0; i < 4 * CPB + 1; i++) stepClk();
        chk("mid bit3 tx", {7'd0, txOUT}, 8'd0);
        chk("mid bit3 nBusy", {7'd0, nBusyOUT}, 8'd0);
        #1;
        nResetIN = 1'b0;
        #1;
        chk("abort tx", {7'd0, txOUT}, 8'd1);
        chk("abort nBusy", {7'd0, nBusyOUT}, 8'd1);
        chk("abort done", {7'd0, doneOUT}, 8'd0);
        stepClk();
        nResetIN = 1'b1;
        stepClk();
        chk("post abort nBusy", {7'd0, nBusyOUT}, 8'd1);
        chk("post abort tx", {7'd0, txOUT}, 8'd1);
        $display("mid-frame reset checked");
        dataIN = 8'h96;
        sendIN = 1'b1;
        stepClk();
        sendIN = 1'b0;
        checkFrame(8'h96, "b96");
        stepClk();
        chk("final done", {7'd0, doneOUT}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
